updown_counter_param: RTL

//  Parametrised up/down counter with bounded range [MIN_VAL..MAX_VAL], runtime step,

---
 rtl/updown_counter_param.sv | 108 ++++++++++
 1 files changed

// File: rtl/updown_counter_param.sv
// Bounded up/down counter over [MIN_VAL..MAX_VAL] with a runtime step, wrap or saturate
// handling at the bounds, synchronous clamped load, and one-cycle wrap/sat event pulses.
module updown_counter_param #(
   parameter int WIDTH     = 8,
   parameter int MIN_VAL   = 0,
   parameter int MAX_VAL   = 2**WIDTH-1,
   parameter int RESET_VAL = MIN_VAL
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] loadValue,
   input  logic             countEnabler,
   input  logic             incOrDec,
   input  logic             satMode,
   input  logic [WIDTH-1:0] step,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             sat,
   output logic             atMax,
   output logic             atMin
);

   // Two guard bits: one for SPAN = 2**WIDTH and count+step, one for the sign of count-step.
   localparam int XW = WIDTH + 2;
   localparam logic signed [XW-1:0] MIN_X  = XW'(MIN_VAL);
   localparam logic signed [XW-1:0] MAX_X  = XW'(MAX_VAL);
   localparam logic signed [XW-1:0] SPAN_X = MAX_X - MIN_X + XW'(1);
   localparam logic [WIDTH-1:0]     MIN_N  = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0]     MAX_N  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0]     RST_N  = WIDTH'(RESET_VAL);

   logic signed [XW-1:0] count_x;
   logic signed [XW-1:0] step_x;
   logic signed [XW-1:0] load_x;
   logic signed [XW-1:0] eff_step;
   logic signed [XW-1:0] up_t;
   logic signed [XW-1:0] dn_t;
   logic signed [XW-1:0] next_x;
   logic [WIDTH-1:0]     count_next;
   logic                 wrap_next;
   logic                 sat_next;
   logic                 unused_high;

   always_comb begin
      count_x    = {2'b00, count};
      step_x     = {2'b00, step};
      load_x     = {2'b00, loadValue};
      eff_step   = (step_x > SPAN_X) ? SPAN_X : step_x;
      up_t       = count_x + eff_step;
      dn_t       = count_x - eff_step;
      next_x     = count_x;
      wrap_next  = 1'b0;
      sat_next   = 1'b0;

      if (load) begin
         if (load_x < MIN_X)
            next_x = MIN_X;
         else if (load_x > MAX_X)
            next_x = MAX_X;
         else
            next_x = load_x;
      end else if (countEnabler) begin
         if (!incOrDec) begin
            if (up_t <= MAX_X) begin
               next_x = up_t;
            end else if (satMode) begin
               next_x   = MAX_X;
               sat_next = 1'b1;
            end else begin
               next_x    = up_t - SPAN_X;
               wrap_next = 1'b1;
            end
         end else begin
            if (dn_t >= MIN_X) begin
               next_x = dn_t;
            end else if (satMode) begin
               next_x   = MIN_X;
               sat_next = 1'b1;
            end else begin
               next_x    = dn_t + SPAN_X;
               wrap_next = 1'b1;
            end
         end
      end

      // Every branch above leaves next_x inside the range, so the guard bits are zero here.
      count_next = next_x[WIDTH-1:0];
   end

   assign unused_high = ^next_x[XW-1:WIDTH];

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         count <= RST_N;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else begin
         count <= count_next;
         wrap  <= wrap_next;
         sat   <= sat_next;
      end
   end

   assign atMax = (count == MAX_N);
   assign atMin = (count == MIN_N);

endmodule
